// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Round-robin arbiter for one shared down-counter. An idle counter is handed
//   to the first requester at or after the round-robin pointer. It loads that
//   requester's length and counts down while enable is high. It then pulses
//   done to the owner for one cycle and returns to idle. The pointer moves past
//   the owner whenever a grant ends, whether by expiry or by abort.
//   Every output is a flop, so no input reaches an output combinationally.
//
// Ports
//   clk      : clock, rising edge
//   reset_in : asynchronous active-high reset
//   req      : [NREQ]   level-sensitive timer requests
//   len      : [NREQ*W] packed lengths, requester i at len[i*W +: W]
//   enable   : count enable; low freezes the counter
//   grant    : [NREQ]   one-hot owner of the counter, zero when unowned
//   done     : [NREQ]   one-cycle expiry pulse to the owner
//   busy     : counter is owned (state is not IDLE)
//   count    : [W]      current counter value
module timer_arbiter #(
  parameter int W    = 8,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic              enable,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    count_q, count_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   sel;
  logic            found;

  // Round-robin scan: first set request at or after rr_ptr. NREQ is a power
  // of two, so the pointer addition wraps modulo NREQ on its own.
  always_comb begin
    logic [PW-1:0] idx;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + PW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (found) begin
          owner_d = sel;
          count_d = len[sel*W +: W];
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A dropped request wins over expiry; an aborted grant gets no done.
        if (!req[owner_q]) begin
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = owner_q + PW'(1);
          state_d  = IDLE;
        end else if (count_q == '0) begin
          done_d  = grant_q;
          state_d = DONE;
        end else if (enable) begin
          count_d = count_q - W'(1);
        end
      end
      DONE: begin
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = owner_q + PW'(1);
        state_d  = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;
  localparam int W    = 8;
  localparam int NREQ = 4;

  logic              clk      = 1'b0;
  logic              reset_in = 1'b0;
  logic [NREQ-1:0]   req      = '0;
  logic [NREQ*W-1:0] len      = '0;
  logic              enable   = 1'b1;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle outputs; cx marks count as don't-care.
  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic [7:0] c;
    logic       cx;
  } exp_t;

  exp_t sb[$];

  timer_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .req      (req),
    .len      (len),
    .enable   (enable),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [3:0] g, logic [3:0] d, logic b, logic [7:0] c, logic cx);
    exp_t e;
    e.g = g; e.d = d; e.b = b; e.c = c; e.cx = cx;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req      = '0;
    len      = '0;
    enable   = 1'b1;
    reset_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_in = 1'b1;
    #1;
    n_tests++;
    if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%b done=%b busy=%b count=%0d, expected all zero", grant, done, busy, count);
    end
    // Reset held through clock edges must keep the arbiter idle.
    req = 4'b1111;
    len = {4{8'd9}};
    tick();
    tick();
    n_tests++;
    if (grant !== 4'b0000 || busy !== 1'b0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_held: grant=%b busy=%b count=%0d, expected 0000/0/0", grant, busy, count);
    end
    reset_in = 1'b0;
    req = '0;
  endtask

  task automatic test_basic();
    exp_t e;
    do_reset();
    req = 4'b0001;
    len[7:0] = 8'd3;
    sb.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd2, 1'b0));
    sb.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd1, 1'b0));
    sb.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0001, 4'b0001, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b0));
    for (int c = 1; c <= 7; c++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if (grant !== e.g || done !== e.d || busy !== e.b || (!e.cx && count !== e.c)) begin
        n_fail++;
        $display("FAIL basic edge%0d: grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
                 c, grant, done, busy, count, e.g, e.d, e.b, e.c);
      end
      if (c == 1) len[7:0] = 8'd7;  // must not affect the running grant
      if (c == 5) req = '0;
    end
  endtask

  task automatic test_len0();
    exp_t e;
    do_reset();
    req = 4'b0010;
    len[15:8] = 8'd0;
    sb.push_back(mk(4'b0010, 4'b0000, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0010, 4'b0010, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b0));
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if (grant !== e.g || done !== e.d || busy !== e.b || (!e.cx && count !== e.c)) begin
        n_fail++;
        $display("FAIL len0 edge%0d: grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
                 c, grant, done, busy, count, e.g, e.d, e.b, e.c);
      end
      if (c == 2) req = '0;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    req = 4'b0100;
    len[23:16] = 8'd4;
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd4, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd2, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd1, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0100, 1'b1, 8'd0, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b0));
    for (int c = 1; c <= 10; c++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if (grant !== e.g || done !== e.d || busy !== e.b || (!e.cx && count !== e.c)) begin
        n_fail++;
        $display("FAIL stall edge%0d: grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
                 c, grant, done, busy, count, e.g, e.d, e.b, e.c);
      end
      if (c == 2) enable = 1'b0;
      if (c == 5) enable = 1'b1;
      if (c == 9) req = '0;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    do_reset();
    req = 4'b1100;
    len[23:16] = 8'd5;
    len[31:24] = 8'd2;
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd5, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd4, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd3, 1'b0));
    sb.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'd2, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'd0, 1'b1));
    sb.push_back(mk(4'b1000, 4'b0000, 1'b1, 8'd2, 1'b0));
    sb.push_back(mk(4'b1000, 4'b0000, 1'b1, 8'd1, 1'b0));
    for (int c = 1; c <= 7; c++) begin
      tick();
      e = sb.pop_front();
      n_tests++;
      if (grant !== e.g || done !== e.d || busy !== e.b || (!e.cx && count !== e.c)) begin
        n_fail++;
        $display("FAIL abort edge%0d: grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
                 c, grant, done, busy, count, e.g, e.d, e.b, e.c);
      end
      if (c == 4) req = 4'b1000;
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] expg[$];
    logic [3:0] prev;
    logic [3:0] cur;
    int ndone;
    do_reset();
    len = {4{8'd1}};
    req = 4'b1111;
    expg.push_back(4'b0001);
    expg.push_back(4'b0010);
    expg.push_back(4'b0100);
    expg.push_back(4'b1000);
    expg.push_back(4'b0001);
    prev  = '0;
    ndone = 0;
    for (int c = 0; c < 40 && expg.size() > 0; c++) begin
      tick();
      if (grant != 4'b0000 && prev == 4'b0000) begin
        cur = expg.pop_front();
        n_tests++;
        if (grant !== cur) begin
          n_fail++;
          $display("FAIL rr_grant: grant=%b, expected %b", grant, cur);
        end
      end
      if (done != 4'b0000) begin
        ndone++;
        n_tests++;
        if (done !== grant) begin
          n_fail++;
          $display("FAIL rr_done_owner: done=%b, expected %b", done, grant);
        end
      end
      prev = grant;
    end
    n_tests++;
    if (expg.size() != 0) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d grants outstanding, expected 0", expg.size());
    end
    n_tests++;
    if (ndone != 4) begin
      n_fail++;
      $display("FAIL rr_done_count: %0d done pulses before fifth grant, expected 4", ndone);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    // Advance rr_ptr past requester 1 so reset's effect on it is visible.
    req = 4'b0010;
    len[15:8] = 8'd0;
    tick();
    tick();
    req = 4'b0110;
    len[15:8]  = 8'd5;
    len[23:16] = 8'd5;
    for (int c = 0; c < 4; c++) tick();
    n_tests++;
    if (grant !== 4'b0100 || count !== 8'd3) begin
      n_fail++;
      $display("FAIL areset_setup: grant=%b count=%0d, expected 0100/3", grant, count);
    end
    #1 reset_in = 1'b1;
    #1;
    n_tests++;
    if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_clear: grant=%b done=%b busy=%b count=%0d, expected all zero", grant, done, busy, count);
    end
    #1 reset_in = 1'b0;
    tick();
    n_tests++;
    if (grant !== 4'b0010 || done !== 4'b0000 || count !== 8'd5) begin
      n_fail++;
      $display("FAIL areset_next: grant=%b done=%b count=%0d, expected 0010/0000/5", grant, done, count);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (done !== 4'b0000) begin
        n_fail++;
        $display("FAIL areset_nodone: done=%b, expected 0000", done);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_abort();
    test_round_robin();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter W, default 8: width of the shared down-counter and of each length field.
REQ-002 Parameter NREQ, default 4: number of requesters; fixed at 4 for this release.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester timer request, level-sensitive.
REQ-006 len  input  NREQ*W  packed count lengths; requester i uses len[i*W +: W].
REQ-007 enable  input  1  count enable; low stalls the counter.
REQ-008 grant  output  NREQ  one-hot owner of the shared counter; all-zero when no owner.
REQ-009 done  output  NREQ  one-hot, one-cycle expiry pulse to the owner.
REQ-010 busy  output  1  high whenever the counter is owned.
REQ-011 count  output  W  current counter value.

Function
REQ-012 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-013 IDLE, any req high: select the first set req at or after rr_ptr, scanning upward with wrap modulo NREQ; load count <= len[sel]; set grant one-hot at sel; go to COUNT.
REQ-014 IDLE, no req: hold; grant=0, done=0, busy=0, count holds its last value.
REQ-015 COUNT, req[owner] low: abort; go to IDLE, grant<=0, no done pulse, rr_ptr <= owner+1 mod NREQ.
REQ-016 COUNT, req[owner] high, count==0: go to DONE.
REQ-017 COUNT, req[owner] high, count!=0, enable=1: count <= count-1; enable=0: count holds.
REQ-018 Abort SHALL take priority over expiry when req[owner] drops in the same cycle that count==0.
REQ-019 DONE: done[owner]=1 for exactly this one cycle; the next state is IDLE with grant<=0 and rr_ptr <= owner+1 mod NREQ.
REQ-020 grant SHALL be nonzero only in COUNT and DONE; busy SHALL be high exactly when state is not IDLE.
REQ-021 All outputs SHALL be driven from registers; no combinational path from any input to any output.
REQ-022 Latency with enable held high SHALL be exactly L+2 cycles from the edge that samples req in IDLE to done high, where L = len[owner].
REQ-023 len=0 SHALL produce done on the cycle after the grant cycle.
REQ-024 Changes on len after the load edge SHALL be ignored for the current grant.
REQ-025 The decrement SHALL never wrap below 0.
REQ-026 A requester whose req is still high after its DONE SHALL be re-arbitrated normally, with rr_ptr already advanced past it.
REQ-027 When req is held continuously, each requester SHALL be granted at most once per NREQ grants.

Reset
REQ-028 reset_in high, asynchronously and independent of clk: state=IDLE, grant=0, done=0, busy=0, count=0, rr_ptr=0.
REQ-029 Reset asserted mid-COUNT or mid-DONE SHALL suppress any pending done pulse.
REQ-030 The first arbitration after reset deasserts SHALL start from requester 0.

Verification
REQ-031 Reset, then req=0001 with len0=3 and enable=1 -> grant=0001 after edge 1; count 3,2,1,0; done=0001 for exactly one cycle after edge 5; then grant=0000 and busy=0.
REQ-032 req=1111 held, all len=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one done pulse per grant.
REQ-033 req=0100 with len2=4, enable low for 3 cycles mid-count -> count frozen during the stall; done arrives 3 cycles later than the REQ-022 value (9 cycles).
REQ-034 req=1100 with len2=5; drop req[2] when count=2 -> no done pulse, grant=0000 for one cycle, then grant=1000.
REQ-035 req=0010 with len1=0 -> grant=0010 at cycle 1, done=0010 at cycle 2.
REQ-036 reset_in pulsed between clock edges at count=3 -> outputs clear immediately without waiting for clk; no done pulse; next grant goes to the lowest-indexed requester.
